// File: rtl/tick_period_meter.sv
// Measures the cycle interval between consecutive one-cycle ticks, checks it
// against EXPECTED +/- TOL, flags a missing tick after MAX_WAIT cycles and counts ticks.
module tick_period_meter #(
  parameter int     WIDTH    = 30,
  parameter longint EXPECTED = 1000000001,
  parameter longint TOL      = 1000,
  parameter longint MAX_WAIT = 1073741823
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             timeout,
  output logic [15:0]      tick_count
);

  // Bounds live at WIDTH+1 bits; the low bound saturates at 0 and both clamp to the top code.
  localparam longint BOUND_MAX = (longint'(1) << (WIDTH + 1)) - 1;
  localparam longint LO_RAW    = (TOL > EXPECTED) ? 0 : EXPECTED - TOL;
  localparam longint HI_RAW    = EXPECTED + TOL;
  localparam longint LO_SAT    = (LO_RAW > BOUND_MAX) ? BOUND_MAX : LO_RAW;
  localparam longint HI_SAT    = (HI_RAW > BOUND_MAX) ? BOUND_MAX : HI_RAW;
  localparam logic [WIDTH:0]   LO    = (WIDTH + 1)'(LO_SAT);
  localparam logic [WIDTH:0]   HI    = (WIDTH + 1)'(HI_SAT);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_WAIT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;

  function automatic logic in_bounds(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] w;
    w = {1'b0, v};
    return (w >= LO) && (w <= HI);
  endfunction

  // Single registered stage: every output is a flop, no combinational path from tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      timeout      <= 1'b0;
      tick_count   <= '0;
    end else begin
      period_valid <= 1'b0;
      if (tick) tick_count <= tick_count + 16'd1;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= MEASURE;
            cnt   <= ONE;
          end
        end
        MEASURE: begin
          // A tick on the limit cycle still closes a valid measurement.
          if (tick) begin
            period       <= cnt;
            period_valid <= 1'b1;
            in_range     <= in_bounds(cnt);
            cnt          <= ONE;
          end else if (cnt == LIMIT) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        TIMEOUT: begin
          if (tick) begin
            state   <= MEASURE;
            cnt     <= ONE;
            timeout <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: scenario tasks plus a timestamp-based reference model.
module tb_tick_period_meter;

  localparam int     WIDTH    = 8;
  localparam longint EXPECTED = 11;
  localparam longint TOL      = 1;
  localparam longint MAX_WAIT = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             in_range;
  logic             timeout;
  logic [15:0]      tick_count;

  tick_period_meter #(
    .WIDTH(WIDTH), .EXPECTED(EXPECTED), .TOL(TOL), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .period(period), .period_valid(period_valid),
    .in_range(in_range), .timeout(timeout), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remembers when the last tick arrived and derives everything from time.
  longint           cyc = 0;
  bit               have_ref;
  longint           last_t;
  logic [WIDTH-1:0] m_period;
  logic             m_valid;
  logic             m_in;
  logic             m_timeout;
  logic [15:0]      m_count;

  function automatic void model_reset();
    have_ref  = 0;
    last_t    = 0;
    m_period  = '0;
    m_valid   = 0;
    m_in      = 0;
    m_timeout = 0;
    m_count   = '0;
  endfunction

  function automatic void model_cycle(input bit t, input bit r);
    longint gap;
    if (r) begin
      model_reset();
      return;
    end
    m_valid = 0;
    if (t) begin
      m_count = m_count + 16'd1;
      if (have_ref) begin
        gap = cyc - last_t;
        if (gap <= MAX_WAIT) begin
          m_valid  = 1;
          m_period = WIDTH'(gap);
          m_in     = (gap >= EXPECTED - TOL) && (gap <= EXPECTED + TOL);
        end
      end
      have_ref = 1;
      last_t   = cyc;
    end
    m_timeout = have_ref && (cyc - last_t >= MAX_WAIT);
  endfunction

  function automatic logic [26:0] dut_vec();
    return {period_valid, period, in_range, timeout, tick_count};
  endfunction

  function automatic logic [26:0] model_vec();
    return {m_valid, m_period, m_in, m_timeout, m_count};
  endfunction

  task automatic step(input bit t, input bit r = 1'b0);
    tick = t;
    rst  = r;
    @(posedge clk);
    model_cycle(t, r);
    cyc++;
    #1;
    tick = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_cmp++;
    if ({period_valid, period, in_range, timeout, tick_count} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int g = 0; g < (k == 0 ? 0 : 10); g++) begin
        step(1'b0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++;
          $display("FAIL periodic_gap: got %h want %h", dut_vec(), model_vec());
        end
      end
      step(1'b1);
      if (period_valid) pulses++;
      n_cmp++;
      if (k > 0 && {period_valid, period, in_range} !== {1'b1, 8'd11, 1'b1}) begin
        n_bad++;
        $display("FAIL periodic_tick: got v=%0b p=%0d r=%0b want v=1 p=11 r=1",
                 period_valid, period, in_range);
      end
    end
    n_cmp++;
    if (pulses !== 4 || tick_count !== 16'd5) begin
      n_bad++;
      $display("FAIL periodic_count: got pulses=%0d cnt=%0d want 4 and 5", pulses, tick_count);
    end
  endtask

  task automatic test_intervals();
    int         gaps[4] = '{10, 12, 13, 9};
    logic [3:0] rng = 4'b1100;
    step(1'b0, 1'b1);
    step(1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int g = 1; g < gaps[k]; g++) step(1'b0);
      step(1'b1);
      n_cmp++;
      if ({period_valid, period, in_range} !== {1'b1, WIDTH'(gaps[k]), rng[3-k]}) begin
        n_bad++;
        $display("FAIL interval_%0d: got v=%0b p=%0d r=%0b want v=1 p=%0d r=%0b",
                 k, period_valid, period, in_range, gaps[k], rng[3-k]);
      end
    end
  endtask

  task automatic test_timeout();
    step(1'b0, 1'b1);
    step(1'b1);
    for (int k = 1; k <= 25; k++) begin
      step(1'b0);
      n_cmp++;
      if (timeout !== (k >= 20)) begin
        n_bad++;
        $display("FAIL timeout_k%0d: got %0b want %0b", k, timeout, k >= 20);
      end
    end
    step(1'b1);
    n_cmp++;
    if ({timeout, period_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_recover: got to=%0b v=%0b want 0 0", timeout, period_valid);
    end
    for (int g = 0; g < 10; g++) step(1'b0);
    step(1'b1);
    n_cmp++;
    if ({period_valid, period} !== {1'b1, 8'd11}) begin
      n_bad++;
      $display("FAIL timeout_after: got v=%0b p=%0d want v=1 p=11", period_valid, period);
    end
  endtask

  task automatic test_max_wait();
    bit seen_to = 0;
    step(1'b0, 1'b1);
    step(1'b1);
    for (int g = 0; g < 19; g++) begin
      step(1'b0);
      seen_to |= timeout;
    end
    step(1'b1);
    seen_to |= timeout;
    n_cmp++;
    if ({period_valid, period, in_range, seen_to} !== {1'b1, 8'd20, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL max_wait: got v=%0b p=%0d r=%0b to=%0b want 1 20 0 0",
               period_valid, period, in_range, seen_to);
    end
    for (int g = 0; g < 20; g++) step(1'b0);
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL max_wait_to: got %0b want 1", timeout);
    end
  endtask

  task automatic test_held();
    int pulses = 0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      if (period_valid) begin
        pulses++;
        n_cmp++;
        if ({period, in_range} !== {8'd1, 1'b0}) begin
          n_bad++;
          $display("FAIL held_pulse: got p=%0d r=%0b want p=1 r=0", period, in_range);
        end
      end
    end
    n_cmp++;
    if (pulses !== 5 || tick_count !== 16'd6) begin
      n_bad++;
      $display("FAIL held_count: got pulses=%0d cnt=%0d want 5 and 6", pulses, tick_count);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1);
    step(1'b1);
    for (int g = 0; g < 6; g++) step(1'b0);
    step(1'b1, 1'b1);
    n_cmp++;
    if (dut_vec() !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want 0", dut_vec());
    end
    step(1'b0);
    step(1'b1);
    n_cmp++;
    if ({period_valid, tick_count} !== {1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL reset_first_tick: got v=%0b cnt=%0d want v=0 cnt=1", period_valid, tick_count);
    end
  endtask

  task automatic test_random();
    step(1'b0, 1'b1);
    for (int k = 0; k < 120; k++) begin
      int gap = $urandom_range(1, 24);
      for (int g = 1; g < gap; g++) begin
        step(1'b0, $urandom_range(0, 299) == 0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++;
          $display("FAIL random_idle: got %h want %h", dut_vec(), model_vec());
        end
      end
      step(1'b1);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL random_tick gap=%0d: got %h want %h", gap, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int bad_here = 0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 65536; k++) begin
      step(1'b1);
      if (dut_vec() !== model_vec()) begin
        bad_here++;
        if (bad_here <= 3) $display("FAIL wrap_cycle %0d: got %h want %h", k, dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (bad_here != 0) n_bad++;
    n_cmp++;
    if (tick_count !== 16'd0) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want 0", tick_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_intervals();
    test_timeout();
    test_max_wait();
    test_held();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Receive-side companion to the periodic tick generator. It consumes a one-cycle tick stream, measures the clock-cycle interval between consecutive ticks, and checks that interval against an expected period with a tolerance. It flags a missing tick after a timeout limit and counts received ticks. It sits between the delay/tick generator and the board LEDs/status logic, so a lab setup can confirm its generated delay in simulation and on hardware.

## Interface
- WIDTH, 30, width of the interval counter and of `period`
- EXPECTED, 1000000001, nominal interval in cycles (tick-to-tick)
- TOL, 1000, allowed ± deviation from EXPECTED, inclusive
- MAX_WAIT, 1073741823, cycles without a tick before timeout; must be ≤ 2^WIDTH−1 and ≥ 1
- clk  input  1  sole clock; all logic on posedge clk
- rst  input  1  synchronous, active-high reset
- tick  input  1  tick pulse; every cycle sampled high counts as one tick
- period  output  WIDTH  last measured interval in cycles; holds until the next valid measurement
- period_valid  output  1  one-cycle pulse; a new `period` is available
- in_range  output  1  registered with `period`: EXPECTED−TOL ≤ period ≤ EXPECTED+TOL
- timeout  output  1  level; no tick seen for MAX_WAIT cycles
- tick_count  output  16  number of ticks received; wraps from 65535 to 0

## Operation
- States: IDLE (no reference tick yet), MEASURE (counting since the last tick), TIMEOUT (limit exceeded).
- Internal counter `cnt` is WIDTH bits wide.
- IDLE:
  - tick → go to MEASURE, cnt←1.
  - No period_valid is produced, because there is no prior reference tick.
- MEASURE:
  - tick → period←cnt, period_valid←1, in_range←compare(cnt), cnt←1, stay in MEASURE.
  - No tick and cnt==MAX_WAIT → go to TIMEOUT, timeout←1, cnt holds.
  - No tick otherwise → cnt←cnt+1.
- TIMEOUT:
  - tick → go to MEASURE, cnt←1, timeout←0.
  - No period_valid is produced, because the interval is invalid.
  - No tick → hold state and hold cnt.
- Tick has priority over timeout: a tick in the same cycle that cnt==MAX_WAIT is a valid measurement with period=MAX_WAIT.
- tick_count increments on every tick, in every state, wrapping modulo 2^16.
- Range compare:
  - Computed at WIDTH+1 bits.
  - The lower bound saturates at 0 when TOL>EXPECTED; no wrap.
- period_valid is low in every cycle except the one after a measuring tick.
- `tick` held high continuously gives period=1 every cycle, with period_valid high every cycle after the first.
- Reset (any cycle, including mid-measurement or during TIMEOUT):
  - state←IDLE, cnt←0, period←0, period_valid←0, in_range←0, timeout←0, tick_count←0.
  - A tick coinciding with rst is ignored.

## Timing
- A tick sampled at cycle t0 gives cnt=1 at t0+1; cnt=k at t0+k.
- A closing tick at t1=t0+P drives period=P, period_valid=1 and in_range at t1+1. Latency is one cycle.
- Back-to-back measurements are supported with no dead cycles.
- Timeout:
  - With no tick after t0, timeout is visible at t0+MAX_WAIT+1.
  - timeout clears at the cycle after the recovering tick.
- tick_count updates at the cycle after each tick.
- All outputs are registered, with no combinational path from tick.
- A generator with terminal count D emits ticks every D+1 cycles; the EXPECTED default matches D=1e9.

## Test plan
Parameters for all scenarios unless stated: WIDTH=8, EXPECTED=11, TOL=1, MAX_WAIT=20.
- Periodic ticks every 11 cycles, 5 ticks:
  - No period_valid after the first tick.
  - Then 4 pulses, each with period=11 and in_range=1, one cycle after each tick.
  - tick_count=5.
- Interval sequence 10, 12, 13, 9:
  - period values 10, 12, 13, 9.
  - in_range values 1, 1, 0, 0.
- Single tick, then silence:
  - timeout=1 exactly 21 cycles after the tick, and it stays high.
  - Next tick: timeout=0 one cycle later, no period_valid.
  - Following tick 11 cycles later: period=11.
- Tick exactly 20 cycles after the previous tick:
  - period=20, period_valid=1, in_range=0, timeout never asserts.
  - Then a gap of 21 cycles: timeout asserts.
- tick held high for 6 cycles:
  - 5 period_valid pulses, each with period=1 and in_range=0.
  - tick_count=6.
- Reset:
  - Assert rst mid-interval (cnt=7) with a tick on the same cycle: all outputs go to 0 and state to IDLE.
  - The next tick produces no period_valid.
  - With WIDTH=8: 65536 ticks wrap tick_count to 0.
